jump_redirect_ctrl: RTL and testbench

Sequencing controller for control-transfer instructions resolved in the EX stage: JAL, JALR and taken conditional branches. It sits between the EX-stage jump/branch datapath and the fetch stage. On each resolved transfer it latches the target and runs a valid/ready redirect handshake with fetch. It also flushes the wrong-path instructions in IF/ID and ID/EX, and stalls EX until the new path is established. Misaligned targets are diverted to a one-cycle exception pulse instead of a redirect.

---
 rtl/rv_ctrl_pkg.sv | 19 +
 rtl/flush_timer.sv | 29 ++
 rtl/jump_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_jump_redirect_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the EX-stage control-transfer sequencing logic:
// FSM state encoding, target alignment mask and reset PC.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  // Low target bits that must be zero for a word-aligned transfer.
  localparam logic [1:0]  ALIGN_MASK = 2'b11;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/flush_timer.sv
// Loadable 4-bit down-counter with a zero flag; times the DRAIN phase
// that keeps IF/ID flushed after fetch accepts a redirect.
module flush_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Sequencing controller for JAL/JALR/taken branches resolved in EX.
// Latches the target, runs a valid/ready redirect handshake with fetch,
// flushes the wrong-path pipeline registers, stalls EX until the new path
// is established, and diverts misaligned targets to a one-cycle exception.
module jump_redirect_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ex_valid,
  input  logic             i_ex_jump,
  input  logic             i_ex_branch,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  input  logic             i_redirect_ready,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_stall_ex,
  output logic             o_misalign_exc,
  output logic [31:0]      o_misalign_addr,
  output logic [CNT_W-1:0] o_taken_count
);

  // A zero-length drain skips the DRAIN state entirely.
  localparam logic       DRAIN_EN   = (FLUSH_CYCLES != 0);
  localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_e            r_state;
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;
  logic              r_flush_if_id;
  logic              r_flush_id_ex;
  logic              r_stall_ex;
  logic              r_misalign_exc;
  logic [31:0]       r_misalign_addr;
  logic [CNT_W-1:0]  r_taken_count;

  logic w_trigger;
  logic w_aligned;
  logic w_accept;
  logic w_drain_done;

  assign w_trigger = i_ex_valid & (i_ex_jump | (i_ex_branch & i_ex_taken));
  assign w_aligned = is_aligned(i_ex_target);
  assign w_accept  = (r_state == ST_REDIRECT) & i_redirect_ready;

  flush_timer u_flush_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (DRAIN_LOAD),
    .i_dec      (r_state == ST_DRAIN),
    .o_zero     (w_drain_done)
  );

  // Redirect FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= RESET_PC;
      r_flush_if_id    <= 1'b0;
      r_flush_id_ex    <= 1'b0;
      r_stall_ex       <= 1'b0;
      r_misalign_exc   <= 1'b0;
      r_misalign_addr  <= 32'h0;
      r_taken_count    <= '0;
    end else begin
      // Exception is a single-cycle pulse unless re-armed below.
      r_misalign_exc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            if (w_aligned) begin
              r_state          <= ST_REDIRECT;
              r_redirect_pc    <= i_ex_target;
              r_redirect_valid <= 1'b1;
              r_flush_if_id    <= 1'b1;
              r_flush_id_ex    <= 1'b1;
              r_stall_ex       <= 1'b1;
            end else begin
              // The trap unit owns the flush for a misaligned transfer.
              r_misalign_exc  <= 1'b1;
              r_misalign_addr <= i_ex_target;
            end
          end
        end
        ST_REDIRECT: begin
          if (i_redirect_ready) begin
            r_taken_count    <= r_taken_count + CNT_W'(1);
            r_redirect_valid <= 1'b0;
            r_flush_id_ex    <= 1'b0;
            r_flush_if_id    <= DRAIN_EN;
            r_stall_ex       <= DRAIN_EN;
            r_state          <= DRAIN_EN ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state       <= ST_IDLE;
            r_flush_if_id <= 1'b0;
            r_stall_ex    <= 1'b0;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_redirect_valid <= 1'b0;
          r_flush_if_id    <= 1'b0;
          r_flush_id_ex    <= 1'b0;
          r_stall_ex       <= 1'b0;
        end
      endcase
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_flush_if_id    = r_flush_if_id;
  assign o_flush_id_ex    = r_flush_id_ex;
  assign o_stall_ex       = r_stall_ex;
  assign o_misalign_exc   = r_misalign_exc;
  assign o_misalign_addr  = r_misalign_addr;
  assign o_taken_count    = r_taken_count;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Scoreboard bench for jump_redirect_ctrl. Instance A uses the default
// build (FLUSH_CYCLES=2, CNT_W=16); instance B is a FLUSH_CYCLES=0,
// CNT_W=4 build used to exercise the zero-drain path and counter wrap.
module tb_jump_redirect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        ex_valid, ex_jump, ex_branch, ex_taken, redirect_ready;
  logic [31:0] ex_target;

  logic        a_rv, a_fif, a_fie, a_stall, a_mexc;
  logic [31:0] a_pc, a_maddr;
  logic [15:0] a_cnt;
  logic        b_rv, b_fif, b_fie, b_stall, b_mexc;
  logic [31:0] b_pc, b_maddr;
  logic [3:0]  b_cnt;

  jump_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .i_ex_valid(ex_valid), .i_ex_jump(ex_jump), .i_ex_branch(ex_branch),
    .i_ex_taken(ex_taken), .i_ex_target(ex_target), .i_redirect_ready(redirect_ready),
    .o_redirect_valid(a_rv), .o_redirect_pc(a_pc), .o_flush_if_id(a_fif),
    .o_flush_id_ex(a_fie), .o_stall_ex(a_stall), .o_misalign_exc(a_mexc),
    .o_misalign_addr(a_maddr), .o_taken_count(a_cnt)
  );

  jump_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .i_ex_valid(ex_valid), .i_ex_jump(ex_jump), .i_ex_branch(ex_branch),
    .i_ex_taken(ex_taken), .i_ex_target(ex_target), .i_redirect_ready(redirect_ready),
    .o_redirect_valid(b_rv), .o_redirect_pc(b_pc), .o_flush_if_id(b_fif),
    .o_flush_id_ex(b_fie), .o_stall_ex(b_stall), .o_misalign_exc(b_mexc),
    .o_misalign_addr(b_maddr), .o_taken_count(b_cnt)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic        rv, fif, fie, stall, mexc;
    logic [31:0] pc;
    bit          pc_chk;
    logic [31:0] maddr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   cur_sel = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input string n, input logic rv, fif, fie, stall, mexc,
                      input logic [31:0] pc, input bit pc_chk,
                      input logic [31:0] maddr, input logic [15:0] cnt);
    exp_t e;
    e.name = n; e.sel = cur_sel;
    e.rv = rv; e.fif = fif; e.fie = fie; e.stall = stall; e.mexc = mexc;
    e.pc = pc; e.pc_chk = pc_chk; e.maddr = maddr; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input string n, input logic [31:0] ma, input logic [15:0] c);
    push(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ma, c);
  endtask
  task automatic exp_redir(input string n, input logic [31:0] pc, input logic [31:0] ma, input logic [15:0] c);
    push(n, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pc, 1'b1, ma, c);
  endtask
  task automatic exp_drain(input string n, input logic [31:0] ma, input logic [15:0] c);
    push(n, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, ma, c);
  endtask
  task automatic exp_mexc(input string n, input logic [31:0] ma, input logic [15:0] c);
    push(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, ma, c);
  endtask
  task automatic exp_reset(input string n);
    push(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 16'h0);
  endtask

  task automatic drv(input logic v, j, b, t, input logic [31:0] tgt, input logic rdy);
    ex_valid = v; ex_jump = j; ex_branch = b; ex_taken = t;
    ex_target = tgt; redirect_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record describes the outputs just after one edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t        e;
        logic [52:0] got_v, want_v;
        logic [31:0] got_pc;
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
          got_v  = {a_rv, a_fif, a_fie, a_stall, a_mexc, a_maddr, a_cnt};
          got_pc = a_pc;
        end else begin
          got_v  = {b_rv, b_fif, b_fie, b_stall, b_mexc, b_maddr, 12'h0, b_cnt};
          got_pc = b_pc;
        end
        want_v = {e.rv, e.fif, e.fie, e.stall, e.mexc, e.maddr, e.cnt};
        check(e.name, {11'h0, got_v}, {11'h0, want_v});
        if (e.pc_chk) check({e.name, "_pc"}, {32'h0, got_pc}, {32'h0, e.pc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drv(0, 0, 0, 0, 32'h0, 0);
    tick();
    tick();

    // ---------------- instance A: FLUSH_CYCLES=2, CNT_W=16 ----------------
    cur_sel = 1'b0;
    exp_reset("reset0"); tick();
    exp_reset("reset1"); tick();
    rst_a = 1'b0;
    exp_idle("idle0", 32'h0, 16'd0); tick();

    // Aligned JAL, ready held high.
    drv(1, 1, 0, 0, 32'h100, 1); exp_redir("jal_redir", 32'h100, 32'h0, 16'd0); tick();
    drv(0, 0, 0, 0, 32'h0, 1);   exp_drain("jal_drain1", 32'h0, 16'd1); tick();
    exp_drain("jal_drain2", 32'h0, 16'd1); tick();
    exp_idle("jal_idle", 32'h0, 16'd1); tick();

    // Taken branch, fetch back-pressures for 5 cycles; EX inputs ignored meanwhile.
    drv(1, 0, 1, 1, 32'h200, 0); exp_redir("br_redir0", 32'h200, 32'h0, 16'd1); tick();
    for (int k = 0; k < 5; k++) begin
      drv(1, 1, 0, 0, 32'h300, 0); exp_redir("br_hold", 32'h200, 32'h0, 16'd1); tick();
    end
    drv(0, 0, 0, 0, 32'h0, 1); exp_drain("br_drain1", 32'h0, 16'd2); tick();
    exp_drain("br_drain2", 32'h0, 16'd2); tick();
    exp_idle("br_idle", 32'h0, 16'd2); tick();

    // Misaligned JALR, then an aligned trigger on the very next cycle.
    drv(1, 1, 0, 0, 32'h102, 1); exp_mexc("jalr_mexc", 32'h102, 16'd2); tick();
    drv(1, 1, 0, 0, 32'h300, 0); exp_redir("mexc_next", 32'h300, 32'h102, 16'd2); tick();
    drv(0, 0, 0, 0, 32'h0, 1);   exp_drain("mexc_drain1", 32'h102, 16'd3); tick();
    exp_drain("mexc_drain2", 32'h102, 16'd3); tick();
    exp_idle("mexc_idle", 32'h102, 16'd3); tick();
    drv(1, 0, 1, 1, 32'h201, 0); exp_mexc("br_mexc", 32'h201, 16'd3); tick();
    drv(0, 0, 0, 0, 32'h0, 0);   exp_idle("mexc_clear", 32'h201, 16'd3); tick();

    // Untaken branch, then a JAL presented during DRAIN and again in IDLE.
    drv(1, 0, 1, 0, 32'h80, 1);  exp_idle("untaken", 32'h201, 16'd3); tick();
    drv(1, 1, 0, 0, 32'h500, 1); exp_redir("jal500", 32'h500, 32'h201, 16'd3); tick();
    drv(1, 1, 0, 0, 32'h40, 1);  exp_drain("drain_ign1", 32'h201, 16'd4); tick();
    exp_drain("drain_ign2", 32'h201, 16'd4); tick();
    exp_idle("drain_ign3", 32'h201, 16'd4); tick();
    drv(1, 1, 0, 0, 32'h40, 0);  exp_redir("jal40", 32'h40, 32'h201, 16'd4); tick();

    // Reset in the middle of a pending handshake.
    drv(0, 0, 0, 0, 32'h0, 0);   exp_redir("jal40_hold", 32'h40, 32'h201, 16'd4); tick();
    rst_a = 1'b1;
    drv(0, 0, 0, 0, 32'h0, 1);   exp_reset("rst_mid"); tick();
    rst_a = 1'b0;
    exp_idle("post_rst", 32'h0, 16'd0); tick();

    // Jump and branch both high: one trigger, same behaviour as the first JAL.
    drv(1, 1, 1, 1, 32'h100, 1); exp_redir("jb_redir", 32'h100, 32'h0, 16'd0); tick();
    drv(0, 0, 0, 0, 32'h0, 1);   exp_drain("jb_drain1", 32'h0, 16'd1); tick();
    exp_drain("jb_drain2", 32'h0, 16'd1); tick();
    exp_idle("jb_idle", 32'h0, 16'd1); tick();

    // ---------------- instance B: FLUSH_CYCLES=0, CNT_W=4 -----------------
    rst_a = 1'b1;
    cur_sel = 1'b1;
    drv(0, 0, 0, 0, 32'h0, 0);
    exp_reset("b_reset"); tick();
    rst_b = 1'b0;
    exp_idle("b_idle", 32'h0, 16'd0); tick();
    for (int i = 0; i < 17; i++) begin
      drv(1, 1, 0, 0, 32'(32'h1000 + i * 4), 1);
      exp_redir("wrap_redir", 32'(32'h1000 + i * 4), 32'h0, 16'(i % 16)); tick();
      drv(0, 0, 0, 0, 32'h0, 1);
      exp_idle("wrap_idle", 32'h0, 16'((i + 1) % 16)); tick();
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
